// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg
// Shared definitions for the GPIO lane arbiter: op encodings, lane geometry
// and the byte-lane read-modify-write function.
package gpio_arb_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam int LANE_W  = 8;
    localparam int N_LANES = 4;

    // New lane value for op applied to current byte l with operand d.
    function automatic logic [LANE_W-1:0] lane_update(
        input logic [1:0]        op,
        input logic [LANE_W-1:0] l,
        input logic [LANE_W-1:0] d
    );
        logic [LANE_W-1:0] r;
        unique case (op)
            OP_WRITE:  r = d;
            OP_SET:    r = l | d;
            OP_CLR:    r = l & ~d;
            default:   r = l ^ d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick over req_mask, searching upward from the
// pointer with wrap. The pointer moves to (winner+1) mod N only on advance.
// Ports:
//   CLOCK_50      clock
//   reset         async active-high reset, pointer -> 0
//   req_mask      eligible requesters
//   advance       commit the current pick (move the pointer)
//   grant_onehot  one-hot winner, zero when nothing is eligible
//   grant_idx     winner index
//   any           at least one requester eligible
module rr_arbiter
    import gpio_arb_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N-1:0]     req_mask,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    int               w_best;
    int               w_off;

    // Winner is the set bit with the smallest distance above the pointer.
    always_comb begin
        w_idx  = '0;
        w_any  = 1'b0;
        w_best = N;
        w_off  = 0;
        for (int j = 0; j < N; j++) begin
            w_off = (j + N - int'(r_ptr)) % N;
            if (req_mask[j] && (w_off < w_best)) begin
                w_best = w_off;
                w_idx  = IDX_W'(j);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N; i++) begin
            grant_onehot[i] = w_any && (w_idx == IDX_W'(i));
        end
    end

    assign grant_idx = w_idx;
    assign any       = w_any;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_any) begin
            r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_lane_arbiter.sv
// gpio_lane_arbiter
// Shares a 32-bit GPIO output register (four byte lanes) between N_REQ
// requesters issuing WRITE/SET/CLR/TOGGLE byte operations via req/ack.
// One operation is applied per clock, chosen round-robin.
// Ports:
//   CLOCK_50   clock
//   reset      async active-high reset
//   clr_all    synchronous load of RESET_VAL, overrides arbitration
//   req        per-requester level request, held until ack
//   op         per-requester op, 2 bits each
//   lane       per-requester byte lane, 2 bits each
//   data       per-requester byte: value or bit mask
//   ack        one-cycle pulse: operation applied
//   gpio_out   registered GPIO value
//   grant_id   index of the last granted requester
//   grant_vld  pulse alongside any ack bit
module gpio_lane_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       clr_all,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         op,
    input  logic [2*N_REQ-1:0]         lane,
    input  logic [8*N_REQ-1:0]         data,
    output logic [N_REQ-1:0]           ack,
    output logic [31:0]                gpio_out,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       grant_vld
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]  r_ack;
    logic [31:0]       r_gpio;
    logic [IDX_W-1:0]  r_grant_id;
    logic              r_grant_vld;

    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_onehot;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_advance;
    logic [1:0]        w_op;
    logic [1:0]        w_lane;
    logic [LANE_W-1:0] w_data;
    logic [31:0]       w_gpio_nxt;

    // A requester in its ack cycle is masked so a still-held req is not
    // executed twice.
    assign w_elig    = req & ~r_ack;
    assign w_advance = w_any & ~clr_all;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .req_mask     (w_elig),
        .advance      (w_advance),
        .grant_onehot (w_onehot),
        .grant_idx    (w_idx),
        .any          (w_any)
    );

    always_comb begin
        w_op   = '0;
        w_lane = '0;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_onehot[i]) begin
                w_op   = op[2*i +: 2];
                w_lane = lane[2*i +: 2];
                w_data = data[LANE_W*i +: LANE_W];
            end
        end
    end

    always_comb begin
        w_gpio_nxt = r_gpio;
        for (int k = 0; k < N_LANES; k++) begin
            if (w_lane == 2'(k)) begin
                w_gpio_nxt[LANE_W*k +: LANE_W] =
                    lane_update(w_op, r_gpio[LANE_W*k +: LANE_W], w_data);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_gpio      <= RESET_VAL;
            r_ack       <= '0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
        end else if (clr_all) begin
            r_gpio      <= RESET_VAL;
            r_ack       <= '0;
            r_grant_vld <= 1'b0;
        end else if (w_any) begin
            r_gpio      <= w_gpio_nxt;
            r_ack       <= w_onehot;
            r_grant_vld <= 1'b1;
            r_grant_id  <= w_idx;
        end else begin
            r_ack       <= '0;
            r_grant_vld <= 1'b0;
        end
    end

    assign ack       = r_ack;
    assign gpio_out  = r_gpio;
    assign grant_id  = r_grant_id;
    assign grant_vld = r_grant_vld;

endmodule

// File: tb/tb_gpio_lane_arbiter.sv
module tb_gpio_lane_arbiter;

    localparam int N_REQ = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        clr_all  = 1'b0;
    logic [3:0]  req      = '0;
    logic [7:0]  op       = '0;
    logic [7:0]  lane     = '0;
    logic [31:0] data     = '0;
    logic [3:0]  ack;
    logic [31:0] gpio_out;
    logic [1:0]  grant_id;
    logic        grant_vld;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the four bytes, rotating priority start, last outputs.
    logic [7:0] m_lane [4];
    int         m_ptr;
    logic [3:0] m_ack;
    logic       m_vld;
    int         m_gid;

    gpio_lane_arbiter #(.N_REQ(4), .RESET_VAL(32'h0)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .clr_all   (clr_all),
        .req       (req),
        .op        (op),
        .lane      (lane),
        .data      (data),
        .ack       (ack),
        .gpio_out  (gpio_out),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] m_gpio();
        return {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_lane[k] = 8'h00;
        m_ptr = 0;
        m_ack = '0;
        m_vld = 1'b0;
        m_gid = 0;
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [1:0] l, input logic [7:0] d);
        op[2*i +: 2]   = o;
        lane[2*i +: 2] = l;
        data[8*i +: 8] = d;
        req[i]         = 1'b1;
    endtask

    // Advance one clock; the model computes the outcome from the inputs as
    // they stand before the edge. Returns at posedge+1.
    task automatic cyc();
        logic [3:0] elig;
        int         w;
        logic [7:0] cur, d;
        elig = req & ~m_ack;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && elig[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        end
        @(posedge CLOCK_50);
        #1;
        if (clr_all) begin
            for (int k = 0; k < 4; k++) m_lane[k] = 8'h00;
            m_ack = '0;
            m_vld = 1'b0;
        end else if (w >= 0) begin
            cur = m_lane[lane[2*w +: 2]];
            d   = data[8*w +: 8];
            case (op[2*w +: 2])
                2'd0: cur = d;
                2'd1: cur = cur | d;
                2'd2: cur = cur & ~d;
                default: cur = cur ^ d;
            endcase
            m_lane[lane[2*w +: 2]] = cur;
            m_ack = 4'b0001 << w;
            m_vld = 1'b1;
            m_gid = w;
            m_ptr = (w + 1) % 4;
        end else begin
            m_ack = '0;
            m_vld = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req = '0; clr_all = 1'b0;
        do_reset();
        n_cmp++;
        if (gpio_out !== 32'h0) begin n_err++; $display("FAIL reset_gpio got %h want %h", gpio_out, 32'h0); end
        n_cmp++;
        if ({ack, grant_vld, grant_id} !== 7'b0) begin n_err++; $display("FAIL reset_ack got ack=%b vld=%b id=%0d want 0", ack, grant_vld, grant_id); end
    endtask

    task automatic test_single_write();
        set_req(0, 2'd0, 2'd2, 8'hA5);
        cyc();
        req[0] = 1'b0;
        n_cmp++;
        if (ack !== 4'b0001 || grant_vld !== 1'b1 || grant_id !== 2'd0) begin
            n_err++; $display("FAIL single_ack got ack=%b vld=%b id=%0d want 0001/1/0", ack, grant_vld, grant_id);
        end
        n_cmp++;
        if (gpio_out !== 32'h00A5_0000) begin n_err++; $display("FAIL single_gpio got %h want 00a50000", gpio_out); end
        cyc();
        n_cmp++;
        if (ack !== 4'b0000 || grant_vld !== 1'b0) begin n_err++; $display("FAIL single_idle got ack=%b vld=%b want 0", ack, grant_vld); end
    endtask

    task automatic test_set_toggle();
        set_req(0, 2'd0, 2'd0, 8'h30);
        cyc();
        n_cmp++;
        if (ack !== 4'b0001 || gpio_out !== 32'h00A5_0030) begin n_err++; $display("FAIL st_write got ack=%b gpio=%h want 0001/00a50030", ack, gpio_out); end
        set_req(0, 2'd1, 2'd0, 8'h0F);
        cyc();
        n_cmp++;
        if (ack !== 4'b0000) begin n_err++; $display("FAIL st_mask1 got ack=%b want 0000", ack); end
        cyc();
        n_cmp++;
        if (ack !== 4'b0001 || gpio_out !== 32'h00A5_003F) begin n_err++; $display("FAIL st_set got ack=%b gpio=%h want 0001/00a5003f", ack, gpio_out); end
        set_req(0, 2'd3, 2'd0, 8'hFF);
        cyc();
        n_cmp++;
        if (ack !== 4'b0000 || gpio_out !== 32'h00A5_003F) begin n_err++; $display("FAIL st_mask2 got ack=%b gpio=%h want 0000/00a5003f", ack, gpio_out); end
        cyc();
        req[0] = 1'b0;
        n_cmp++;
        if (ack !== 4'b0001 || gpio_out !== 32'h00A5_00C0) begin n_err++; $display("FAIL st_toggle got ack=%b gpio=%h want 0001/00a500c0", ack, gpio_out); end
        cyc();
        n_cmp++;
        if (ack !== 4'b0000 || gpio_out !== 32'h00A5_00C0) begin n_err++; $display("FAIL st_once got ack=%b gpio=%h want 0000/00a500c0", ack, gpio_out); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 2'd0, 2'd0, 8'(i));
        for (int c = 0; c < 8; c++) begin
            cyc();
            n_cmp++;
            if (ack !== (4'b0001 << (c % 4)) || grant_vld !== 1'b1 || grant_id !== 2'(c % 4)) begin
                n_err++; $display("FAIL rr_grant c=%0d got ack=%b vld=%b id=%0d want id=%0d", c, ack, grant_vld, grant_id, c % 4);
            end
            n_cmp++;
            if (gpio_out[7:0] !== 8'(c % 4)) begin n_err++; $display("FAIL rr_lane0 c=%0d got %h want %h", c, gpio_out[7:0], 8'(c % 4)); end
        end
        req = '0;
        cyc();
    endtask

    task automatic test_clr_all();
        set_req(0, 2'd0, 2'd0, 8'h78);
        set_req(1, 2'd0, 2'd1, 8'h56);
        set_req(2, 2'd0, 2'd2, 8'h34);
        set_req(3, 2'd0, 2'd3, 8'h12);
        for (int c = 0; c < 8; c++) begin
            cyc();
            req = req & ~m_ack;
        end
        n_cmp++;
        if (gpio_out !== 32'h1234_5678) begin n_err++; $display("FAIL clr_setup got %h want 12345678", gpio_out); end
        clr_all = 1'b1;
        set_req(1, 2'd0, 2'd3, 8'hFF);
        cyc();
        clr_all = 1'b0;
        n_cmp++;
        if (gpio_out !== 32'h0 || ack !== 4'b0000 || grant_vld !== 1'b0) begin
            n_err++; $display("FAIL clr_apply got gpio=%h ack=%b vld=%b want 0/0000/0", gpio_out, ack, grant_vld);
        end
        cyc();
        req[1] = 1'b0;
        n_cmp++;
        if (ack !== 4'b0010 || grant_id !== 2'd1 || gpio_out !== 32'hFF00_0000) begin
            n_err++; $display("FAIL clr_after got ack=%b id=%0d gpio=%h want 0010/1/ff000000", ack, grant_id, gpio_out);
        end
    endtask

    task automatic test_async_reset();
        set_req(2, 2'd0, 2'd1, 8'h3C);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (gpio_out !== 32'h0 || ack !== 4'b0000 || grant_vld !== 1'b0) begin
            n_err++; $display("FAIL areset_now got gpio=%h ack=%b vld=%b want 0", gpio_out, ack, grant_vld);
        end
        @(posedge CLOCK_50);
        #1;
        n_cmp++;
        if (gpio_out !== 32'h0 || ack !== 4'b0000) begin n_err++; $display("FAIL areset_hold got gpio=%h ack=%b want 0", gpio_out, ack); end
        reset = 1'b0;
        model_reset();
        cyc();
        req[2] = 1'b0;
        n_cmp++;
        if (ack !== 4'b0100 || grant_id !== 2'd2 || gpio_out !== 32'h0000_3C00) begin
            n_err++; $display("FAIL areset_after got ack=%b id=%0d gpio=%h want 0100/2/00003c00", ack, grant_id, gpio_out);
        end
    endtask

    task automatic test_withdraw();
        set_req(0, 2'd0, 2'd1, 8'h11);
        set_req(1, 2'd0, 2'd2, 8'h77);
        cyc();
        req[1] = 1'b0;
        n_cmp++;
        if (ack !== 4'b0001) begin n_err++; $display("FAIL wd_first got ack=%b want 0001", ack); end
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_cmp++;
            if (ack[1] !== 1'b0 || gpio_out !== 32'h0000_1100) begin
                n_err++; $display("FAIL wd_noack c=%0d got ack=%b gpio=%h want ack1=0/00001100", c, ack, gpio_out);
            end
        end
        req = '0;
        cyc();
    endtask

    task automatic new_op(input int i);
        set_req(i, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (m_ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else new_op(i);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 1) == 0) new_op(i);
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            clr_all = ($urandom_range(0, 15) == 0);
            cyc();
            n_cmp++;
            if (gpio_out !== m_gpio()) begin n_err++; $display("FAIL rnd_gpio c=%0d got %h want %h", c, gpio_out, m_gpio()); end
            n_cmp++;
            if (ack !== m_ack || grant_vld !== m_vld || grant_id !== 2'(m_gid)) begin
                n_err++; $display("FAIL rnd_grant c=%0d got ack=%b vld=%b id=%0d want %b/%b/%0d", c, ack, grant_vld, grant_id, m_ack, m_vld, m_gid);
            end
        end
        clr_all = 1'b0;
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_set_toggle();
        test_round_robin();
        test_clr_all();
        test_async_reset();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_lane_arbiter.md
Name: gpio_lane_arbiter

Overview:
- Shares the 32-bit GPIO output register, organised as four byte lanes, between N_REQ independent requesters.
- Each requester issues byte-lane operations (write/set/clear/toggle) through a req/ack handshake.
- A round-robin arbiter grants at most one operation per clock.
- Sits between the user logic (switch decoders, counters, demo FSMs) and the GPIO header drive.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- RESET_VAL, 32'h00000000, value loaded into gpio_out on reset and on clr_all.

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr_all  input  1  synchronous clear: load RESET_VAL into gpio_out.
- req  input  N_REQ  per-requester request, level, held until ack.
- op  input  2*N_REQ  per-requester op, slice [2i+1:2i]: 00 WRITE, 01 SET, 10 CLR, 11 TOGGLE.
- lane  input  2*N_REQ  per-requester byte lane, slice [2i+1:2i], lane k = gpio_out[8k+7:8k].
- data  input  8*N_REQ  per-requester byte, slice [8i+7:8i]: value for WRITE, bit mask for SET/CLR/TOGGLE.
- ack  output  N_REQ  one-cycle pulse: the requester's operation has been applied.
- gpio_out  output  32  registered GPIO output value.
- grant_id  output  clog2(N_REQ)  index of the last granted requester.
- grant_vld  output  1  pulse, high in the same cycle as any ack bit.

Behaviour:
- Reset (asynchronous, active-high):
  - gpio_out = RESET_VAL, ack = 0, grant_vld = 0, grant_id = 0.
  - Round-robin pointer = 0, so requester 0 has first priority.
- Reset mid-operation: the pending request is dropped with no ack. The requester keeps req high and is re-arbitrated after reset releases.
- Eligibility: requester i is eligible in cycle t when req[i]=1 and ack[i]=0 in cycle t. This masks the ack cycle and prevents double execution of a held request.
- Arbitration: combinational round-robin over eligible requesters.
  - Search starts at the pointer and wraps from N_REQ-1 to 0.
  - Winner w is chosen in cycle t.
- Edge ending cycle t:
  - gpio_out lane[w] is updated.
  - ack[w]=1, grant_vld=1 and grant_id=w during cycle t+1.
  - Pointer becomes (w+1) mod N_REQ.
  - Latency from req rise to ack is 1 cycle when uncontested. Worst case is N_REQ cycles.
- Lane update, with L = current lane byte and D = data byte:
  - WRITE: L ← D.
  - SET: L ← L | D.
  - CLR: L ← L & ~D.
  - TOGGLE: L ← L ^ D.
  - Other lanes are unchanged.
- No eligible requester: ack = 0, grant_vld = 0, and gpio_out, grant_id and the pointer hold.
- Throughput:
  - At most one operation per cycle in total.
  - A single requester holding req continuously is served every second cycle, because of the ack mask.
  - Other requesters may fill the gap cycles.
- Handshake rules:
  - op, lane and data must stay stable while req is high and until the ack cycle.
  - Dropping req before ack withdraws the request. It is not an error, and no ack is generated.
- clr_all has priority over arbitration:
  - gpio_out ← RESET_VAL, no grant, no ack, pointer holds.
  - Pending requests remain pending and are served after clr_all deasserts, applied on top of RESET_VAL.
- Two requesters writing the same lane are serialised in grant order. The later operation sees the earlier result.

Decomposition:
- Package gpio_arb_pkg:
  - Op encoding constants OP_WRITE, OP_SET, OP_CLR, OP_TOGGLE.
  - LANE_W = 8 and N_LANES = 4.
  - Lane-update function (op, L, D) → new L.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: CLOCK_50, reset, req_mask[N], advance, grant_onehot[N], grant_idx, any.
  - Holds the pointer, which updates only when advance=1.
- Top level contains the eligibility mask, the lane datapath, and the ack/grant_vld/grant_id registers.

Test Plan:
- Reset → gpio_out=00000000, ack=0. Req0 WRITE lane2 data A5 → one cycle later ack=0001, gpio_out=00A50000, grant_id=0.
- Req0 SET lane0 0F then TOGGLE lane0 FF, with gpio_out lane0 = 30 → 3F, then C0. Each op acks exactly once, and a held req gives acks 2 cycles apart.
- Req[3:0]=1111 held, all WRITE lane0 with data=index → grant order 0,1,2,3,0… with one grant per cycle. Each ack[i] occurs no more often than every second cycle. gpio_out[7:0] follows 00,01,02,03.
- clr_all=1 in the same cycle as req1 WRITE lane3 FF, with gpio_out=12345678 → gpio_out=00000000 and no ack. After clr_all drops, ack[1] arrives and gpio_out=FF000000.
- Req2 high, then reset pulsed asynchronously mid-cycle → gpio_out=00000000 immediately, ack=0, no ack for that cycle. The op is applied one cycle after reset release.
- Req1 asserted then dropped before its grant while req0 is being served → no ack[1] and lane unchanged.
